// File: rtl/frame_word_fifo.sv
// frame_word_fifo: packs RMII dibits into words and holds them speculatively until the FCS verdict.
// Optional last-word tag output axiol is enabled by defining FRAME_WORD_FIFO_LAST_EN.
module frame_word_fifo #(
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_50mhz,
   input  logic                  rst,
   input  logic                  axiiv,
   input  logic [1:0]            axiid,
   input  logic                  fcs_done,
   input  logic                  fcs_kill,
   output logic                  axiov,
   output logic [WORD_WIDTH-1:0] axiod,
`ifdef FRAME_WORD_FIFO_LAST_EN
   output logic                  axiol,
`endif
   input  logic                  axior,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_WIDTH-1:0]  frame_count,
   output logic [CNT_WIDTH-1:0]  drop_count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   localparam int DPW = WORD_WIDTH / 2;
   localparam int DW  = $clog2(DPW);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_RECV     = 2'd1;
   localparam logic [1:0] S_DROP     = 2'd2;
   localparam logic [1:0] S_WAIT_FCS = 2'd3;

   localparam logic [PW-1:0]        PTR_ONE    = PW'(1);
   localparam logic [PW-1:0]        PTR_DEPTH  = PW'(DEPTH);
   localparam logic [DW-1:0]        LAST_DIBIT = DW'(DPW - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

   logic [1:0]            state_r, state_s;
   logic [PW-1:0]         wr_ptr_r, wr_ptr_s;
   logic [PW-1:0]         cm_ptr_r, cm_ptr_s;
   logic [PW-1:0]         rd_ptr_r;
   logic [DW-1:0]         dcnt_r, dcnt_s;
   logic [WORD_WIDTH-3:0] sh_r, sh_s;
   logic                  bad_r, bad_s;
   logic                  done_d_r, kill_d_r;
   logic [CNT_WIDTH-1:0]  frame_count_r, drop_count_r;
   logic [WORD_WIDTH-1:0] mem_r [DEPTH];

   logic                  done_rise_s, kill_rise_s;
   logic                  axiov_s, rd_fire_s, full_s, word_done_s;
   logic [WORD_WIDTH-1:0] word_s;
   logic                  take_s, wr_en_s, frame_inc_s, drop_inc_s, last_set_s;

   // Status, edge detection and the packed word candidate
   always_comb begin
      done_rise_s = fcs_done & ~done_d_r;
      kill_rise_s = fcs_kill & ~kill_d_r;
      axiov_s     = (cm_ptr_r != rd_ptr_r);
      rd_fire_s   = axiov_s & axior;
      full_s      = ((wr_ptr_r - rd_ptr_r) == PTR_DEPTH);
      word_done_s = axiiv & (dcnt_r == LAST_DIBIT);
      word_s      = {sh_r, axiid};
   end

   // Frame state machine, speculative pointer moves and dibit packer
   always_comb begin
      state_s     = state_r;
      wr_ptr_s    = wr_ptr_r;
      cm_ptr_s    = cm_ptr_r;
      dcnt_s      = dcnt_r;
      sh_s        = sh_r;
      bad_s       = bad_r;
      take_s      = 1'b0;
      wr_en_s     = 1'b0;
      frame_inc_s = 1'b0;
      drop_inc_s  = 1'b0;
      last_set_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (axiiv) begin
               state_s = S_RECV;
               bad_s   = 1'b0;
               take_s  = 1'b1;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_RECV: begin
            if (!axiiv) begin
               state_s    = S_WAIT_FCS;
               dcnt_s     = {DW{1'b0}};
               last_set_s = (wr_ptr_r != cm_ptr_r);
            end else if (word_done_s && full_s && !rd_fire_s) begin
               // No room even after this cycle's read: abandon the whole frame
               state_s  = S_DROP;
               bad_s    = 1'b1;
               wr_ptr_s = cm_ptr_r;
               dcnt_s   = {DW{1'b0}};
            end else begin
               take_s = 1'b1;
            end
         end
         S_DROP: begin
            if (!axiiv) begin
               state_s = S_WAIT_FCS;
            end else begin
               state_s = S_DROP;
            end
         end
         S_WAIT_FCS: begin
            if (kill_rise_s || (done_rise_s && bad_r)) begin
               wr_ptr_s   = cm_ptr_r;
               drop_inc_s = 1'b1;
               state_s    = S_IDLE;
            end else if (done_rise_s) begin
               cm_ptr_s    = wr_ptr_r;
               frame_inc_s = 1'b1;
               state_s     = S_IDLE;
            end else if (axiiv) begin
               wr_ptr_s   = cm_ptr_r;
               drop_inc_s = 1'b1;
            end else begin
               state_s = S_WAIT_FCS;
            end
            // A new frame may start while still waiting; its first dibit is kept
            if (axiiv) begin
               state_s = S_RECV;
               bad_s   = 1'b0;
               take_s  = 1'b1;
            end else begin
               take_s = 1'b0;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
      if (take_s) begin
         sh_s = word_s[WORD_WIDTH-3:0];
         if (dcnt_r == LAST_DIBIT) begin
            wr_en_s  = 1'b1;
            wr_ptr_s = wr_ptr_r + PTR_ONE;
            dcnt_s   = {DW{1'b0}};
         end else begin
            dcnt_s = dcnt_r + DW'(1);
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Control registers, pointers and saturating statistics
   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         state_r       <= S_IDLE;
         wr_ptr_r      <= {PW{1'b0}};
         cm_ptr_r      <= {PW{1'b0}};
         rd_ptr_r      <= {PW{1'b0}};
         dcnt_r        <= {DW{1'b0}};
         bad_r         <= 1'b0;
         done_d_r      <= 1'b0;
         kill_d_r      <= 1'b0;
         frame_count_r <= {CNT_WIDTH{1'b0}};
         drop_count_r  <= {CNT_WIDTH{1'b0}};
      end else begin
         state_r  <= state_s;
         wr_ptr_r <= wr_ptr_s;
         cm_ptr_r <= cm_ptr_s;
         dcnt_r   <= dcnt_s;
         bad_r    <= bad_s;
         done_d_r <= fcs_done;
         kill_d_r <= fcs_kill;
         if (rd_fire_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (frame_inc_s && (frame_count_r != CNT_MAX)) begin
            frame_count_r <= frame_count_r + CNT_WIDTH'(1);
         end
         if (drop_inc_s && (drop_count_r != CNT_MAX)) begin
            drop_count_r <= drop_count_r + CNT_WIDTH'(1);
         end
      end
   end

   // Shift register and word storage need no reset
   always_ff @(posedge clk_50mhz) begin
      sh_r <= sh_s;
      if (wr_en_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= word_s;
      end
   end

`ifdef FRAME_WORD_FIFO_LAST_EN
   logic last_mem_r [DEPTH];
   logic [AW-1:0] last_idx_s;

   // Index of the most recently written word of the frame being closed
   always_comb begin
      last_idx_s = wr_ptr_r[AW-1:0] - AW'(1);
   end

   // The last tag is only known once the frame ends, so it is set retroactively
   always_ff @(posedge clk_50mhz) begin
      if (wr_en_s) begin
         last_mem_r[wr_ptr_r[AW-1:0]] <= 1'b0;
      end else if (last_set_s) begin
         last_mem_r[last_idx_s] <= 1'b1;
      end
   end

   assign axiol = axiov_s & last_mem_r[rd_ptr_r[AW-1:0]];
`endif

   assign axiov       = axiov_s;
   assign axiod       = mem_r[rd_ptr_r[AW-1:0]];
   assign full        = full_s;
   assign empty       = ~axiov_s;
   assign frame_count = frame_count_r;
   assign drop_count  = drop_count_r;

endmodule
